// File: rtl/switch_link_pkg.sv
// Shared chiplet link types: the flit format carried between switch ports.
package switch_link_pkg;

  localparam int VC_W   = 1;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] data;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);

endpackage

// File: rtl/switch_link_pipe.sv
// Valid-plus-payload delay line; DEPTH register stages, DEPTH=0 is a plain wire.
module link_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_s;

      assign unused_clk_s = clk ^ n_rst;
      assign out_valid    = in_valid;
      assign out_data     = in_data;
      assign busy         = 1'b0;
    end else begin : g_regs
      logic [DEPTH-1:0] valid_r;
      logic [WIDTH-1:0] data_r [DEPTH];

      // Shift stages; payload only moves with a valid so idle slots never capture garbage.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          valid_r <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            data_r[i] <= '0;
          end
        end else begin
          valid_r[0] <= in_valid;
          if (in_valid) begin
            data_r[0] <= in_data;
          end
          for (int i = 1; i < DEPTH; i++) begin
            valid_r[i] <= valid_r[i-1];
            if (valid_r[i-1]) begin
              data_r[i] <= data_r[i-1];
            end
          end
        end
      end

      assign out_valid = valid_r[DEPTH-1];
      assign out_data  = data_r[DEPTH-1];
      assign busy      = |valid_r;
    end
  endgenerate

endmodule

// File: rtl/switch_link.sv
// Credit-based point-to-point link between a switch outport and a downstream inport.
module switch_link
  import switch_link_pkg::*;
#(
  parameter int NUM_VCS        = 2,
  parameter int BUFFER_SIZE    = 8,
  parameter int LINK_LATENCY   = 1,
  parameter int CREDIT_LATENCY = 1
) (
  input  logic                                          clk,
  input  logic                                          n_rst,
  input  flit_t                                         tx_flit,
  input  logic                                          tx_valid,
  output logic                                          tx_ready,
  output flit_t                                         rx_flit,
  output logic                                          rx_valid,
  input  logic [NUM_VCS-1:0]                            rx_credit_return,
  output logic [NUM_VCS-1:0][$clog2(BUFFER_SIZE+1)-1:0] credit_count,
  output logic                                          credit_error,
  output logic                                          link_idle
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  // The counter register is the last credit stage, so the pipe holds one fewer.
  localparam int CRED_DEPTH = CREDIT_LATENCY - 1;
  localparam logic [CW-1:0] MAX_CREDIT = CW'(BUFFER_SIZE);

  logic [NUM_VCS-1:0][CW-1:0] credit_count_r;
  logic [NUM_VCS-1:0][CW-1:0] credit_next_s;
  logic                       credit_error_r;
  logic                       error_set_s;
  logic                       ready_s;
  logic                       accept_s;
  logic [FLIT_W-1:0]          fwd_data_s;
  logic                       fwd_busy_s;
  logic                       cred_valid_s;
  logic [NUM_VCS-1:0]         cred_data_s;
  logic                       cred_busy_s;
  logic [NUM_VCS-1:0]         inc_s;
  logic [NUM_VCS-1:0]         dec_s;
  logic                       all_full_s;

  // Credit availability for the VC currently offered.
  always_comb begin
    ready_s = (credit_count_r[tx_flit.vc] != {CW{1'b0}});
  end

  assign accept_s = tx_valid & ready_s;
  assign tx_ready = ready_s;

  link_pipe #(
    .WIDTH (FLIT_W),
    .DEPTH (LINK_LATENCY)
  ) u_fwd_pipe (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (accept_s),
    .in_data   (tx_flit),
    .out_valid (rx_valid),
    .out_data  (fwd_data_s),
    .busy      (fwd_busy_s)
  );

  assign rx_flit = flit_t'(fwd_data_s);

  link_pipe #(
    .WIDTH (NUM_VCS),
    .DEPTH (CRED_DEPTH)
  ) u_cred_pipe (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (|rx_credit_return),
    .in_data   (rx_credit_return),
    .out_valid (cred_valid_s),
    .out_data  (cred_data_s),
    .busy      (cred_busy_s)
  );

  // Per-VC increment and decrement requests for this cycle.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      inc_s[v] = cred_valid_s & cred_data_s[v];
      dec_s[v] = accept_s & (tx_flit.vc == VC_W'(v));
    end
  end

  // Next credit count; a credit arriving on a full counter is an overflow.
  always_comb begin
    credit_next_s = credit_count_r;
    error_set_s   = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      case ({inc_s[v], dec_s[v]})
        2'b10: begin
          if (credit_count_r[v] == MAX_CREDIT) begin
            error_set_s      = 1'b1;
            credit_next_s[v] = MAX_CREDIT;
          end else begin
            credit_next_s[v] = credit_count_r[v] + CW'(1);
          end
        end
        2'b01: begin
          if (credit_count_r[v] == {CW{1'b0}}) begin
            error_set_s      = 1'b1;
            credit_next_s[v] = credit_count_r[v];
          end else begin
            credit_next_s[v] = credit_count_r[v] - CW'(1);
          end
        end
        2'b11: begin
          if (credit_count_r[v] == MAX_CREDIT) begin
            error_set_s = 1'b1;
          end else begin
            error_set_s = error_set_s;
          end
          credit_next_s[v] = credit_count_r[v];
        end
        default: begin
          credit_next_s[v] = credit_count_r[v];
        end
      endcase
    end
  end

  // Credit counters and the sticky error flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      credit_count_r <= {NUM_VCS{MAX_CREDIT}};
      credit_error_r <= 1'b0;
    end else begin
      credit_count_r <= credit_next_s;
      credit_error_r <= credit_error_r | error_set_s;
    end
  end

  // Idle means nothing in either pipe and every VC back at full credit.
  always_comb begin
    all_full_s = 1'b1;
    for (int v = 0; v < NUM_VCS; v++) begin
      all_full_s = all_full_s & (credit_count_r[v] == MAX_CREDIT);
    end
  end

  assign link_idle    = all_full_s & ~fwd_busy_s & ~cred_busy_s;
  assign credit_count = credit_count_r;
  assign credit_error = credit_error_r;

endmodule

// File: tb/tb_switch_link.sv
// Randomized and directed bench for switch_link against a timestamp-based link model.
module tb_switch_link;
  import switch_link_pkg::*;

  localparam int NV = 2;
  localparam int B  = 8;
  localparam int L  = 3;
  localparam int CL = 2;

  logic                 clk;
  logic                 n_rst;
  flit_t                tx_flit;
  logic                 tx_valid;
  logic                 tx_ready;
  flit_t                rx_flit;
  logic                 rx_valid;
  logic [NV-1:0]        rx_credit_return;
  logic [NV-1:0][3:0]   credit_count;
  logic                 credit_error;
  logic                 link_idle;

  switch_link #(
    .NUM_VCS        (NV),
    .BUFFER_SIZE    (B),
    .LINK_LATENCY   (L),
    .CREDIT_LATENCY (CL)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .tx_flit          (tx_flit),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_flit          (rx_flit),
    .rx_valid         (rx_valid),
    .rx_credit_return (rx_credit_return),
    .credit_count     (credit_count),
    .credit_error     (credit_error),
    .link_idle        (link_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Model: flits scheduled by delivery cycle, credits stamped with their pulse cycle.
  typedef struct {
    int    due;
    flit_t f;
  } fwd_t;

  fwd_t          fwd_q[$];
  logic [NV-1:0] cred_at[int];
  int            cnt[NV];
  int            owed[NV];
  bit            err_m;
  int            mcyc;
  bit            acc_now;
  int            acc_vc;
  int            rx_seen;
  bit            want_rst;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at model cycle %0d", name, got, exp, mcyc);
    end
  endtask

  function automatic flit_t mk(input logic vc, input logic [31:0] d);
    flit_t f;
    f.vc   = vc;
    f.head = d[31];
    f.tail = d[0];
    f.data = d;
    return f;
  endfunction

  task automatic model_reset();
    fwd_q.delete();
    cred_at.delete();
    for (int v = 0; v < NV; v++) begin
      cnt[v]  = B;
      owed[v] = 0;
    end
    err_m   = 1'b0;
    acc_now = 1'b0;
  endtask

  // Compare every output against the model for the current cycle, then record this cycle's inputs.
  task automatic model_check();
    bit    in_flight;
    bit    full;
    bit    exp_ready;
    bit    exp_v;
    flit_t exp_f;
    if (!n_rst) model_reset();
    in_flight = (fwd_q.size() != 0);
    for (int p = mcyc - CL + 1; p < mcyc; p++) begin
      if (cred_at.exists(p) && cred_at[p] != '0) in_flight = 1'b1;
    end
    full = 1'b1;
    for (int v = 0; v < NV; v++) begin
      if (cnt[v] != B) full = 1'b0;
    end
    exp_ready = (cnt[tx_flit.vc] != 0);
    exp_v     = 1'b0;
    exp_f     = '0;
    if (fwd_q.size() > 0 && fwd_q[0].due == mcyc) begin
      exp_v = 1'b1;
      exp_f = fwd_q[0].f;
      void'(fwd_q.pop_front());
    end
    chk("tx_ready", 64'(tx_ready), 64'(exp_ready));
    chk("rx_valid", 64'(rx_valid), 64'(exp_v));
    if (exp_v) chk("rx_flit", 64'(rx_flit), 64'(exp_f));
    for (int v = 0; v < NV; v++) begin
      chk("credit_count", 64'(credit_count[v]), 64'(cnt[v]));
    end
    chk("credit_error", 64'(credit_error), 64'(err_m));
    chk("link_idle", 64'(link_idle), 64'(full && !in_flight));
    if (rx_valid) rx_seen++;
    acc_now = n_rst && tx_valid && exp_ready;
    if (acc_now) begin
      fwd_q.push_back('{due: mcyc + L, f: tx_flit});
      acc_vc = int'(tx_flit.vc);
      owed[acc_vc]++;
    end
    if (n_rst) begin
      cred_at[mcyc] = rx_credit_return;
      for (int v = 0; v < NV; v++) begin
        if (rx_credit_return[v]) owed[v]--;
      end
    end
  endtask

  task automatic drive(input logic v, input logic vc, input logic [31:0] d, input logic [NV-1:0] cr);
    @(negedge clk);
    n_rst            = !want_rst;
    tx_valid         = v;
    tx_flit          = mk(vc, d);
    rx_credit_return = cr;
    #2;
    model_check();
  endtask

  // Rising edge: apply this cycle's acceptance and the credits that have finished their delay.
  task automatic advance();
    bit inc;
    bit dec;
    @(posedge clk);
    if (!n_rst) begin
      model_reset();
    end else begin
      for (int v = 0; v < NV; v++) begin
        inc = cred_at.exists(mcyc + 1 - CL) && cred_at[mcyc + 1 - CL][v];
        dec = acc_now && (acc_vc == v);
        if (inc && cnt[v] == B) err_m = 1'b1;
        if (inc && !dec) cnt[v] = (cnt[v] < B) ? cnt[v] + 1 : B;
        else if (dec && !inc) cnt[v] = cnt[v] - 1;
      end
    end
    mcyc++;
  endtask

  task automatic step(input logic v, input logic vc, input logic [31:0] d, input logic [NV-1:0] cr);
    drive(v, vc, d, cr);
    advance();
  endtask

  initial begin
    logic [NV-1:0] cr;
    int            seen0;
    n_checks         = 0;
    n_errors         = 0;
    mcyc             = 0;
    rx_seen          = 0;
    acc_vc           = 0;
    n_rst            = 1'b0;
    want_rst         = 1'b1;
    tx_valid         = 1'b0;
    tx_flit          = '0;
    rx_credit_return = '0;
    model_reset();

    // Reset values
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("rst_count0", 64'(credit_count[0]), 64'd8);
    chk("rst_count1", 64'(credit_count[1]), 64'd8);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx_flit", 64'(rx_flit), 64'd0);
    chk("rst_error", 64'(credit_error), 64'd0);
    chk("rst_idle", 64'(link_idle), 64'd1);
    advance();
    step(1'b0, 1'b0, 32'd0, 2'b00);
    want_rst = 1'b0;
    step(1'b0, 1'b0, 32'd0, 2'b00);
    step(1'b0, 1'b0, 32'd0, 2'b00);

    // Single VC0 flit with three-cycle link
    drive(1'b1, 1'b0, 32'hA5A5_0001, 2'b00);
    chk("lat_ready", 64'(tx_ready), 64'd1);
    advance();
    step(1'b0, 1'b0, 32'd0, 2'b00);
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("lat_not_early", 64'(rx_valid), 64'd0);
    advance();
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("lat_rx_valid", 64'(rx_valid), 64'd1);
    chk("lat_rx_data", 64'(rx_flit.data), 64'hA5A5_0001);
    chk("lat_count0", 64'(credit_count[0]), 64'd7);
    advance();
    step(1'b0, 1'b0, 32'd0, 2'b01);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 2'b00);

    // Eight back-to-back VC1 flits exhaust the credits; the ninth is refused
    seen0 = rx_seen;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'h1100_0000 + 32'(i), 2'b00);
    drive(1'b1, 1'b1, 32'h1100_00FF, 2'b00);
    chk("full_ready_low", 64'(tx_ready), 64'd0);
    chk("full_count1", 64'(credit_count[1]), 64'd0);
    advance();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h1100_00FF, 2'b00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 2'b10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 2'b00);
    chk("full_rx_count", 64'(rx_seen - seen0), 64'd8);
    chk("full_restored", 64'(credit_count[1]), 64'd8);

    // VC0 drained to zero, one credit returns with two-cycle credit latency
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0C00_0000 + 32'(i), 2'b00);
    step(1'b0, 1'b0, 32'd0, 2'b00);
    drive(1'b0, 1'b0, 32'd0, 2'b01);
    chk("cred_ready_t0", 64'(tx_ready), 64'd0);
    advance();
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("cred_ready_t1", 64'(tx_ready), 64'd0);
    advance();
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("cred_ready_t2", 64'(tx_ready), 64'd1);
    chk("cred_count_t2", 64'(credit_count[0]), 64'd1);
    advance();

    // Simultaneous acceptance and delayed credit on VC0 at count 4
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 2'b01);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'd0, 2'b00);
    drive(1'b0, 1'b0, 32'd0, 2'b01);
    chk("simul_before", 64'(credit_count[0]), 64'd4);
    advance();
    drive(1'b1, 1'b0, 32'h5100_0004, 2'b00);
    chk("simul_mid", 64'(credit_count[0]), 64'd4);
    advance();
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("simul_after", 64'(credit_count[0]), 64'd4);
    advance();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 2'b01);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 2'b00);
    chk("simul_restored", 64'(credit_count[0]), 64'd8);

    // Spurious credit on a full VC1
    step(1'b0, 1'b1, 32'd0, 2'b10);
    step(1'b0, 1'b1, 32'd0, 2'b00);
    drive(1'b0, 1'b1, 32'd0, 2'b00);
    chk("ovf_count1", 64'(credit_count[1]), 64'd8);
    chk("ovf_error", 64'(credit_error), 64'd1);
    advance();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 2'b00);
    chk("ovf_sticky", 64'(credit_error), 64'd1);

    // Reset with two flits in flight
    step(1'b1, 1'b0, 32'hDEAD_0000, 2'b00);
    step(1'b1, 1'b1, 32'hDEAD_0001, 2'b00);
    want_rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
    advance();
    step(1'b0, 1'b0, 32'd0, 2'b00);
    want_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'd0, 2'b00);
      chk("post_rst_rx_valid", 64'(rx_valid), 64'd0);
      chk("post_rst_count0", 64'(credit_count[0]), 64'd8);
      chk("post_rst_count1", 64'(credit_count[1]), 64'd8);
      chk("post_rst_idle", 64'(link_idle), 64'd1);
      chk("post_rst_error", 64'(credit_error), 64'd0);
      advance();
    end

    // Random traffic with legitimate credit returns and one brief reset
    for (int i = 0; i < 3000; i++) begin
      cr = '0;
      want_rst = (i >= 1500 && i < 1502);
      for (int v = 0; v < NV; v++) begin
        if (owed[v] > 0 && $urandom_range(0, 2) == 0) cr[v] = 1'b1;
      end
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom, cr);
    end
    want_rst = 1'b0;

    // Drain: return everything still owed
    for (int i = 0; i < 40; i++) begin
      cr = '0;
      for (int v = 0; v < NV; v++) begin
        if (owed[v] > 0) cr[v] = 1'b1;
      end
      step(1'b0, 1'b0, 32'd0, cr);
    end
    drive(1'b0, 1'b0, 32'd0, 2'b00);
    chk("drain_idle", 64'(link_idle), 64'd1);
    chk("drain_count0", 64'(credit_count[0]), 64'd8);
    chk("drain_count1", 64'(credit_count[1]), 64'd8);
    advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
